// File: rtl/rvc_asap_5pl_fetch_if.sv
// rvc_asap_5pl_fetch_if: stall/redirect/I_MEM inputs and decode-facing outputs of the fetch stage.
// Revision: 1.0
`default_nettype none

interface rvc_asap_5pl_fetch_if;
  logic        StallQ101H;
  logic        RedirectQ102H;
  logic [31:0] RedirectPcQ102H;
  logic [31:0] ImemRdDataQ101H;
  logic [31:0] Pc;
  logic [31:0] PcQ101H;
  logic [31:0] PcPlus4Q101H;
  logic [31:0] InstQ101H;
  logic        ValidQ101H;
  logic        MisalignErr;
  logic [31:0] FetchCnt;

  modport master (
    output StallQ101H, RedirectQ102H, RedirectPcQ102H, ImemRdDataQ101H,
    input  Pc, PcQ101H, PcPlus4Q101H, InstQ101H, ValidQ101H, MisalignErr, FetchCnt
  );

  modport slave (
    input  StallQ101H, RedirectQ102H, RedirectPcQ102H, ImemRdDataQ101H,
    output Pc, PcQ101H, PcPlus4Q101H, InstQ101H, ValidQ101H, MisalignErr, FetchCnt
  );
endinterface

`default_nettype wire

// File: rtl/rvc_asap_5pl_fetch.sv
// rvc_asap_5pl_fetch: Q100H/Q101H fetch front end with PC, stall replay and redirect bubbles.
// Revision: 1.0
`default_nettype none

module rvc_asap_5pl_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic                    Clock,
  input  logic                    Rst,
  rvc_asap_5pl_fetch_if.slave     bus
);

  logic [31:0] r_pc;
  logic [31:0] r_pc_q101;
  logic [31:0] r_hold;
  logic        r_replay_sel;
  logic        r_kill_next;
  logic        r_misalign;
  logic [31:0] r_fetch_cnt;

  logic [31:0] w_raw;
  logic        w_valid;

  // During a stall I_MEM already returns the next word, so replay the captured one.
  assign w_raw   = r_replay_sel ? r_hold : bus.ImemRdDataQ101H;
  assign w_valid = !r_kill_next && !bus.RedirectQ102H;

  always_ff @(posedge Clock) begin
    if (Rst) begin
      r_pc         <= RESET_PC;
      r_pc_q101    <= RESET_PC;
      r_hold       <= NOP_INST;
      r_replay_sel <= 1'b0;
      r_kill_next  <= 1'b1;
      r_misalign   <= 1'b0;
      r_fetch_cnt  <= 32'd0;
    end else begin
      if (bus.RedirectQ102H)
        r_pc <= {bus.RedirectPcQ102H[31:2], 2'b00};
      else if (!bus.StallQ101H)
        r_pc <= r_pc + 32'd4;

      if (!bus.StallQ101H || bus.RedirectQ102H)
        r_pc_q101 <= r_pc;

      if (!r_replay_sel)
        r_hold <= w_raw;

      r_replay_sel <= bus.StallQ101H && !bus.RedirectQ102H;
      r_kill_next  <= bus.RedirectQ102H;

      if (bus.RedirectQ102H && (bus.RedirectPcQ102H[1:0] != 2'b00))
        r_misalign <= 1'b1;

      if (w_valid && !bus.StallQ101H)
        r_fetch_cnt <= r_fetch_cnt + 32'd1;
    end
  end

  assign bus.Pc           = r_pc;
  assign bus.PcQ101H      = r_pc_q101;
  assign bus.PcPlus4Q101H = r_pc_q101 + 32'd4;
  assign bus.ValidQ101H   = w_valid;
  assign bus.InstQ101H    = w_valid ? w_raw : NOP_INST;
  assign bus.MisalignErr  = r_misalign;
  assign bus.FetchCnt     = r_fetch_cnt;

endmodule

`default_nettype wire

// File: tb/tb_rvc_asap_5pl_fetch.sv
// tb_rvc_asap_5pl_fetch: per-cycle vector table with a scoreboard queue for the fetch stage.
// Revision: 1.0
`default_nettype none

module tb_rvc_asap_5pl_fetch;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic Clock;
  logic Rst;
  rvc_asap_5pl_fetch_if bus ();

  rvc_asap_5pl_fetch dut (
    .Clock (Clock),
    .Rst   (Rst),
    .bus   (bus.slave)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return 32'h0050_0093 ^ {a[23:0], 8'h00};
  endfunction

  // Synchronous-read instruction memory: word of the previous cycle's Pc.
  always @(posedge Clock) bus.ImemRdDataQ101H <= memf(bus.Pc);

  typedef struct {
    logic        rst;
    logic        stall;
    logic        redir;
    logic [31:0] rpc;
    logic [31:0] pc;
    logic [31:0] pcq;
    logic        valid;
    logic [31:0] inst;
    logic [31:0] cnt;
    logic        mis;
  } vec_t;

  vec_t vt[24];
  vec_t sb[$];
  int   errs   = 0;
  int   checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp, input int row);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL row %0d %s: got %h expected %h", row, name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic rst, input logic stall, input logic redir,
                              input logic [31:0] rpc, input logic [31:0] pc, input logic [31:0] pcq,
                              input logic valid, input logic [31:0] inst, input logic [31:0] cnt,
                              input logic mis);
    vec_t v;
    v.rst = rst; v.stall = stall; v.redir = redir; v.rpc = rpc;
    v.pc = pc; v.pcq = pcq; v.valid = valid; v.inst = inst; v.cnt = cnt; v.mis = mis;
    return v;
  endfunction

  initial begin
    // Free run from reset: bubble first, then PC 0.
    vt[0]  = mk(0,0,0,0, 32'h0,   32'h0,   0, NOP,              0, 0);
    vt[1]  = mk(0,0,0,0, 32'h4,   32'h0,   1, memf(32'h0),      0, 0);
    vt[2]  = mk(0,0,0,0, 32'h8,   32'h4,   1, memf(32'h4),      1, 0);
    // Three stall cycles plus release: word of 0x8 replayed throughout.
    vt[3]  = mk(0,1,0,0, 32'hC,   32'h8,   1, memf(32'h8),      2, 0);
    vt[4]  = mk(0,1,0,0, 32'hC,   32'h8,   1, memf(32'h8),      2, 0);
    vt[5]  = mk(0,1,0,0, 32'hC,   32'h8,   1, memf(32'h8),      2, 0);
    vt[6]  = mk(0,0,0,0, 32'hC,   32'h8,   1, memf(32'h8),      2, 0);
    vt[7]  = mk(0,0,0,0, 32'h10,  32'hC,   1, memf(32'hC),      3, 0);
    // Redirect to 0x100 while Q101H holds 0x10.
    vt[8]  = mk(0,0,1,32'h100, 32'h14, 32'h10, 0, NOP,           4, 0);
    vt[9]  = mk(0,0,0,0, 32'h100, 32'h14,  0, NOP,              4, 0);
    // Redirect and stall together.
    vt[10] = mk(0,1,1,32'h200, 32'h104, 32'h100, 0, NOP,         4, 0);
    vt[11] = mk(0,0,0,0, 32'h200, 32'h104, 0, NOP,              4, 0);
    vt[12] = mk(0,0,0,0, 32'h204, 32'h200, 1, memf(32'h200),    4, 0);
    // Misaligned redirect target.
    vt[13] = mk(0,0,1,32'h102, 32'h208, 32'h204, 0, NOP,         5, 0);
    vt[14] = mk(0,0,0,0, 32'h100, 32'h208, 0, NOP,              5, 1);
    vt[15] = mk(0,1,0,0, 32'h104, 32'h100, 1, memf(32'h100),    5, 1);
    // Reset during a stall with a pending (misaligned) redirect.
    vt[16] = mk(1,1,1,32'h301, 32'h104, 32'h100, 0, NOP,         5, 1);
    vt[17] = mk(0,0,0,0, 32'h0,   32'h0,   0, NOP,              0, 0);
    vt[18] = mk(0,0,0,0, 32'h4,   32'h0,   1, memf(32'h0),      0, 0);
    // Pc wrap through 0xFFFF_FFFC.
    vt[19] = mk(0,0,1,32'hFFFF_FFF8, 32'h8, 32'h4, 0, NOP,       1, 0);
    vt[20] = mk(0,0,0,0, 32'hFFFF_FFF8, 32'h8, 0, NOP,          1, 0);
    vt[21] = mk(0,0,0,0, 32'hFFFF_FFFC, 32'hFFFF_FFF8, 1, memf(32'hFFFF_FFF8), 1, 0);
    vt[22] = mk(0,0,0,0, 32'h0,   32'hFFFF_FFFC, 1, memf(32'hFFFF_FFFC), 2, 0);
    vt[23] = mk(0,0,0,0, 32'h4,   32'h0,   1, memf(32'h0),      3, 0);

    Rst = 1'b1;
    bus.StallQ101H      = 1'b0;
    bus.RedirectQ102H   = 1'b0;
    bus.RedirectPcQ102H = 32'h0;
    repeat (2) @(posedge Clock);

    for (int i = 0; i < 24; i++) begin
      vec_t e;
      @(negedge Clock);
      Rst                 = vt[i].rst;
      bus.StallQ101H      = vt[i].stall;
      bus.RedirectQ102H   = vt[i].redir;
      bus.RedirectPcQ102H = vt[i].rpc;
      sb.push_back(vt[i]);
      #1;
      e = sb.pop_front();
      check("Pc",           bus.Pc,           e.pc,            i);
      check("PcQ101H",      bus.PcQ101H,      e.pcq,           i);
      check("PcPlus4Q101H", bus.PcPlus4Q101H, e.pcq + 32'd4,   i);
      check("ValidQ101H",   {31'd0, bus.ValidQ101H},  {31'd0, e.valid}, i);
      check("InstQ101H",    bus.InstQ101H,    e.inst,          i);
      check("FetchCnt",     bus.FetchCnt,     e.cnt,           i);
      check("MisalignErr",  {31'd0, bus.MisalignErr}, {31'd0, e.mis},   i);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errs + 1, checks + 1);
    $fatal(1);
  end

endmodule

`default_nettype wire
